// File: rtl/mmio_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : mmio_bus_ctrl_pkg
// Purpose: Shared definitions for the MMIO bus controller: FSM state
//          encoding, default UART register addresses, status word layout and
//          counter widths.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package mmio_bus_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE           = 4'd0,
    ST_RAM_RD         = 4'd1,
    ST_RAM_WR         = 4'd2,
    ST_UART_RD        = 4'd3,
    ST_UART_WR        = 4'd4,
    ST_UART_WAIT_TBRE = 4'd5,
    ST_UART_WAIT_TSRE = 4'd6,
    ST_STAT_RD        = 4'd7,
    ST_DONE           = 4'd8
  } state_t;

  localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

  // Status register bit positions
  localparam int STAT_TX_READY_BIT = 0;
  localparam int STAT_RX_READY_BIT = 1;

  localparam int STROBE_CNT_W  = 4;
  localparam int TIMEOUT_CNT_W = 10;

  function automatic logic [15:0] status_word(input logic rx_ready,
                                              input logic tx_ready);
    logic [15:0] w;
    w                    = '0;
    w[STAT_RX_READY_BIT] = rx_ready;
    w[STAT_TX_READY_BIT] = tx_ready;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_bus_ctrl_strobe_timer.sv
`default_nettype none
// ============================================================================
// Module : mmio_bus_ctrl_strobe_timer
// Purpose: Loadable down-counter timing the active phase of a bus strobe.
//          'last' is high in the final cycle of the strobe.
// Ports  : Clk0     - clock
//          Rst      - asynchronous active-low reset
//          load     - reload count with load_val (held high outside strobe
//                     states so the counter is primed on entry)
//          load_val - cycles-1 of the strobe
//          last     - count has reached zero
// Rev    : 1.0  initial release
// ============================================================================
module mmio_bus_ctrl_strobe_timer #(
  parameter int WIDTH = 4
) (
  input  logic             Clk0,
  input  logic             Rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge Clk0 or negedge Rst) begin
    if (!Rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule
`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mmio_bus_ctrl
// Purpose: Multi-cycle MMIO bus controller behind the MEM-stage data port.
//          Converts one latched load/store into Ram1 or UART strobes on the
//          shared 16-bit Ram1 data bus, returns read data with a one-cycle
//          Done pulse and holds Busy while the access is in flight.
// Ports  : Clk0/Rst             - board clock, async active-low reset
//          Req/Addr/WData/
//          MemRead/MemWrite     - request from the pipeline
//          RData/Done/Busy/Err  - response to the pipeline
//          Ram1_*               - Ram1 SRAM control, address and data bus
//          rdn/wrn              - UART read/write strobes (active-low)
//          data_ready/tbre/tsre - UART status inputs
// Config : define MMIO_UART_TIMEOUT_EN to bound the UART transmit waits by
//          TIMEOUT_CYC cycles and report expiry on Err.
// Rev    : 1.0  initial release
// ============================================================================
module mmio_bus_ctrl
  import mmio_bus_ctrl_pkg::*;
#(
  parameter int          STROBE_CYC     = 2,
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
  parameter int          TIMEOUT_CYC    = 1023
) (
  input  logic        Clk0,
  input  logic        Rst,
  input  logic        Req,
  input  logic [15:0] Addr,
  input  logic [15:0] WData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [15:0] RData,
  output logic        Done,
  output logic        Busy,
  output logic        Err,
  output logic        Ram1_EN,
  output logic        Ram1_OE,
  output logic        Ram1_WE,
  output logic [17:0] Ram1_address,
  inout  wire  [15:0] Ram1_data,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);

  if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe_cyc
    $error("mmio_bus_ctrl: STROBE_CYC must be 1..15");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_timeout_cyc
    $error("mmio_bus_ctrl: TIMEOUT_CYC must be 1..1023");
  end

  localparam logic [STROBE_CNT_W-1:0] STROBE_LOAD = STROBE_CNT_W'(STROBE_CYC - 1);

  state_t      state;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        is_write_q;
  logic        strobe_load;
  logic        strobe_last;

  // Timer is held loaded everywhere except the strobe states, so every
  // strobe state starts with a fresh count on entry.
  assign strobe_load = !(state inside {ST_RAM_RD, ST_RAM_WR, ST_UART_RD, ST_UART_WR});

  mmio_bus_ctrl_strobe_timer #(
    .WIDTH (STROBE_CNT_W)
  ) u_strobe_timer (
    .Clk0     (Clk0),
    .Rst      (Rst),
    .load     (strobe_load),
    .load_val (STROBE_LOAD),
    .last     (strobe_last)
  );

  assign Ram1_address = {2'b00, addr_q};
  assign Ram1_data    = (state == ST_RAM_WR || state == ST_UART_WR) ? wdata_q : 16'hzzzz;

`ifdef MMIO_UART_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_CNT_W'(TIMEOUT_CYC);
  logic [TIMEOUT_CNT_W-1:0] tmo_cnt;
  logic                     err_q;
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  always_ff @(posedge Clk0 or negedge Rst) begin
    if (!Rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      RData      <= '0;
      Done       <= 1'b0;
      Busy       <= 1'b0;
      Ram1_EN    <= 1'b1;
      Ram1_OE    <= 1'b1;
      Ram1_WE    <= 1'b1;
      rdn        <= 1'b1;
      wrn        <= 1'b1;
`ifdef MMIO_UART_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
`ifdef MMIO_UART_TIMEOUT_EN
      // Cleared by default; only the wait states keep it counting.
      tmo_cnt <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (Req && (MemRead || MemWrite)) begin
            addr_q     <= Addr;
            wdata_q    <= WData;
            is_write_q <= MemWrite;   // write wins when both are set
            Busy       <= 1'b1;
`ifdef MMIO_UART_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            if (Addr == UART_DATA_ADDR) begin
              if (MemWrite) begin
                state <= ST_UART_WR;
                wrn   <= 1'b0;
              end else begin
                state <= ST_UART_RD;
                rdn   <= 1'b0;
              end
            end else if (Addr == UART_STAT_ADDR) begin
              state <= ST_STAT_RD;
            end else begin
              Ram1_EN <= 1'b0;
              if (MemWrite) begin
                state   <= ST_RAM_WR;
                Ram1_WE <= 1'b0;
              end else begin
                state   <= ST_RAM_RD;
                Ram1_OE <= 1'b0;
              end
            end
          end
        end

        ST_RAM_RD: begin
          if (strobe_last) begin
            RData   <= Ram1_data;
            Ram1_EN <= 1'b1;
            Ram1_OE <= 1'b1;
            state   <= ST_DONE;
            Done    <= 1'b1;
            Busy    <= 1'b0;
          end
        end

        ST_RAM_WR: begin
          if (strobe_last) begin
            Ram1_EN <= 1'b1;
            Ram1_WE <= 1'b1;
            state   <= ST_DONE;
            Done    <= 1'b1;
            Busy    <= 1'b0;
          end
        end

        ST_UART_RD: begin
          if (strobe_last) begin
            RData <= {8'h00, Ram1_data[7:0]};
            rdn   <= 1'b1;
            state <= ST_DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end
        end

        ST_UART_WR: begin
          if (strobe_last) begin
            wrn   <= 1'b1;
            state <= ST_UART_WAIT_TBRE;
          end
        end

        ST_UART_WAIT_TBRE: begin
          if (tbre) begin
            state <= ST_UART_WAIT_TSRE;
          end
`ifdef MMIO_UART_TIMEOUT_EN
          else if (tmo_cnt == TIMEOUT_LIMIT) begin
            state <= ST_DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ST_UART_WAIT_TSRE: begin
          if (tsre) begin
            state <= ST_DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end
`ifdef MMIO_UART_TIMEOUT_EN
          else if (tmo_cnt == TIMEOUT_LIMIT) begin
            state <= ST_DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ST_STAT_RD: begin
          // Status register is read-only; a store to it completes as a no-op.
          if (!is_write_q) begin
            RData <= status_word(data_ready, tbre & tsre);
          end
          state <= ST_DONE;
          Done  <= 1'b1;
          Busy  <= 1'b0;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_mmio_bus_ctrl
// Purpose: Self-checking bench for mmio_bus_ctrl: table of single accesses
//          plus hand-written UART store, reset abort and UART wait sequences.
//          Honours MMIO_UART_TIMEOUT_EN the same way as the design.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mmio_bus_ctrl;

  localparam int STROBE_CYC  = 2;
  localparam int TIMEOUT_CYC = 1023;

  logic        Clk0 = 1'b0;
  logic        Rst  = 1'b1;
  logic        Req = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
  logic [15:0] Addr = '0, WData = '0;
  logic        data_ready = 1'b0, tbre = 1'b0, tsre = 1'b0;
  logic [15:0] RData;
  logic        Done, Busy, Err;
  logic        Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn;
  logic [17:0] Ram1_address;
  wire  [15:0] Ram1_data;

  // Memory/UART model drives the bus whenever the DUT asks for read data.
  logic [15:0] model_val = '0;
  logic        model_drive;
  assign model_drive = (!Ram1_EN && !Ram1_OE) || !rdn;
  assign Ram1_data   = model_drive ? model_val : 16'hzzzz;

  always #5 Clk0 = ~Clk0;

  mmio_bus_ctrl #(
    .STROBE_CYC     (STROBE_CYC),
    .UART_DATA_ADDR (16'hBF00),
    .UART_STAT_ADDR (16'hBF01),
    .TIMEOUT_CYC    (TIMEOUT_CYC)
  ) dut (
    .Clk0         (Clk0),
    .Rst          (Rst),
    .Req          (Req),
    .Addr         (Addr),
    .WData        (WData),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .RData        (RData),
    .Done         (Done),
    .Busy         (Busy),
    .Err          (Err),
    .Ram1_EN      (Ram1_EN),
    .Ram1_OE      (Ram1_OE),
    .Ram1_WE      (Ram1_WE),
    .Ram1_address (Ram1_address),
    .Ram1_data    (Ram1_data),
    .rdn          (rdn),
    .wrn          (wrn),
    .data_ready   (data_ready),
    .tbre         (tbre),
    .tsre         (tsre)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] bus;       // value the model returns on reads
    logic        dr;
    logic        tb;
    logic        ts;
    logic [15:0] exp_rdata; // RData in the Done cycle
    int          exp_lat;   // cycle (1 = first after acceptance) Done is high
    int          exp_we;    // cycles Ram1_WE low
    int          exp_oe;    // cycles Ram1_OE low
    int          exp_rdn;   // cycles rdn low
    int          exp_en;    // cycles Ram1_EN low
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One access; returns what was observed. Leaves the DUT back in IDLE.
  task automatic run_txn(input vec_t v, output int lat, output logic [15:0] rd,
                         output int we_n, output int oe_n, output int rdn_n,
                         output int en_n, output int wrn_n, output logic bus_ok,
                         output logic busy_ok, output logic released);
    @(negedge Clk0);
    Addr = v.addr; WData = v.wdata; MemRead = v.rd; MemWrite = v.wr;
    data_ready = v.dr; tbre = v.tb; tsre = v.ts; model_val = v.bus;
    Req = 1'b1;
    @(posedge Clk0);
    lat = 0; rd = '0; we_n = 0; oe_n = 0; rdn_n = 0; en_n = 0; wrn_n = 0;
    bus_ok = 1'b1; busy_ok = 1'b1; released = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      Req = 1'b0;
      if (!Ram1_WE) begin
        we_n++;
        if (Ram1_data !== v.wdata || Ram1_address !== {2'b00, v.addr}) bus_ok = 1'b0;
      end
      if (!Ram1_OE) oe_n++;
      if (!rdn) rdn_n++;
      if (!Ram1_EN) en_n++;
      if (!wrn) wrn_n++;
      if (Done) begin
        lat      = c;
        rd       = RData;
        if (Busy) busy_ok = 1'b0;
        released = (Ram1_data !== v.wdata);
        break;
      end
      if (!Busy) busy_ok = 1'b0;
      @(posedge Clk0);
    end
    @(posedge Clk0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int          lat, we_n, oe_n, rdn_n, en_n, wrn_n, k, done_k;
    logic [15:0] rd;
    logic        bus_ok, busy_ok, released, flag, err_seen;

    //         wr    rd    addr      wdata     bus       dr    tb    ts    exp_rd   lat we oe rdn en
    vecs[0] = '{1'b1, 1'b0, 16'h4000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 2, 0, 0, 2};
    vecs[1] = '{1'b0, 1'b1, 16'h4000, 16'h5A5A, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'hBEEF, 3, 0, 2, 0, 2};
    vecs[2] = '{1'b0, 1'b1, 16'h0123, 16'h5A5A, 16'h0F0F, 1'b0, 1'b0, 1'b0, 16'h0F0F, 3, 0, 2, 0, 2};
    vecs[3] = '{1'b0, 1'b1, 16'hBF00, 16'h5A5A, 16'h3C7F, 1'b1, 1'b0, 1'b0, 16'h007F, 3, 0, 0, 2, 0};
    vecs[4] = '{1'b0, 1'b1, 16'hBF01, 16'h5A5A, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0002, 2, 0, 0, 0, 0};
    vecs[5] = '{1'b0, 1'b1, 16'hBF01, 16'h5A5A, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 2, 0, 0, 0, 0};
    vecs[6] = '{1'b0, 1'b1, 16'hBF01, 16'h5A5A, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0003, 2, 0, 0, 0, 0};
    vecs[7] = '{1'b1, 1'b1, 16'h4002, 16'hCAFE, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0003, 3, 2, 0, 0, 2};
    vecs[8] = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 3, 2, 0, 0, 2};

    // Reset state
    #1 Rst = 1'b0;
    #11;
    check("reset_outputs", {11'd0, RData, Done, Busy, Err, Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn},
          {11'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
    @(negedge Clk0) Rst = 1'b1;
    @(negedge Clk0);

    // Table of single accesses
    for (int i = 0; i < NVEC; i++) begin
      run_txn(vecs[i], lat, rd, we_n, oe_n, rdn_n, en_n, wrn_n, bus_ok, busy_ok, released);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
      check($sformatf("v%0d_we_cycles", i), we_n, vecs[i].exp_we);
      check($sformatf("v%0d_oe_cycles", i), oe_n, vecs[i].exp_oe);
      check($sformatf("v%0d_rdn_cycles", i), rdn_n, vecs[i].exp_rdn);
      check($sformatf("v%0d_en_cycles", i), en_n, vecs[i].exp_en);
      check($sformatf("v%0d_wrn_cycles", i), wrn_n, 0);
      check($sformatf("v%0d_store_bus_addr", i), {31'd0, bus_ok}, 1);
      check($sformatf("v%0d_busy_profile", i), {31'd0, busy_ok}, 1);
      check($sformatf("v%0d_bus_released_at_done", i), {31'd0, released}, 1);
    end

    // Req without MemRead/MemWrite is ignored
    @(negedge Clk0);
    Req = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = 16'h4000;
    flag = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk0); #1;
      if (Busy || Done || !Ram1_EN) flag = 1'b1;
    end
    Req = 1'b0;
    check("ignored_req_no_activity", {31'd0, flag}, 0);

    // UART store with delayed tbre/tsre
    @(negedge Clk0);
    Addr = 16'hBF00; WData = 16'h0041; MemWrite = 1'b1; MemRead = 1'b0;
    tbre = 1'b0; tsre = 1'b0; Req = 1'b1;
    @(posedge Clk0);
    k = -1; done_k = -1; wrn_n = 0; en_n = 0; bus_ok = 1'b1; err_seen = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      #1;
      Req = 1'b0;
      if (!wrn) begin
        wrn_n++;
        if (Ram1_data !== 16'h0041) bus_ok = 1'b0;
      end
      if (!Ram1_EN) en_n++;
      if (k < 0 && wrn_n > 0 && wrn) k = 0;
      else if (k >= 0) k++;
      if (Done) begin
        done_k   = k;
        err_seen = Err;
        break;
      end
      if (k == 5) tbre = 1'b1;
      if (k == 8) tsre = 1'b1;
      @(posedge Clk0);
    end
    @(posedge Clk0);
    check("uart_wr_wrn_cycles", wrn_n, 2);
    check("uart_wr_ram1_en_low_cycles", en_n, 0);
    check("uart_wr_bus_data", {31'd0, bus_ok}, 1);
    check("uart_wr_done_after_tsre", done_k, 9);
    check("uart_wr_err", {31'd0, err_seen}, 0);

    // Reset abort during RAM_WR
    @(negedge Clk0);
    Addr = 16'h4000; WData = 16'h1234; MemWrite = 1'b1; MemRead = 1'b0; Req = 1'b1;
    @(posedge Clk0); #1;
    Req = 1'b0;
    check("abort_we_active_before_reset", {31'd0, Ram1_WE}, 0);
    #2 Rst = 1'b0;
    #1;
    check("abort_outputs_immediate", {28'd0, Ram1_WE, Ram1_EN, Busy, Done}, {28'd0, 4'b1100});
    check("abort_bus_released", {31'd0, (Ram1_data !== 16'h1234)}, 1);
    @(negedge Clk0);
    @(negedge Clk0) Rst = 1'b1;
    flag = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge Clk0); #1;
      if (Done || Busy) flag = 1'b1;
    end
    check("abort_no_done", {31'd0, flag}, 0);
    run_txn(vecs[1], lat, rd, we_n, oe_n, rdn_n, en_n, wrn_n, bus_ok, busy_ok, released);
    check("post_abort_read_latency", lat, 3);
    check("post_abort_read_rdata", {16'd0, rd}, {16'd0, 16'hBEEF});

    // UART store with tsre stuck low
    @(negedge Clk0);
    Addr = 16'hBF00; WData = 16'h0055; MemWrite = 1'b1; MemRead = 1'b0;
    tbre = 1'b1; tsre = 1'b0; Req = 1'b1;
    @(posedge Clk0);
`ifdef MMIO_UART_TIMEOUT_EN
    lat = 0; err_seen = 1'b0; busy_ok = 1'b1;
    for (int c = 1; c <= TIMEOUT_CYC + 40; c++) begin
      #1;
      Req = 1'b0;
      if (Done) begin
        lat      = c;
        err_seen = Err;
        break;
      end
      if (!Busy) busy_ok = 1'b0;
      @(posedge Clk0);
    end
    @(posedge Clk0);
    check("timeout_latency_in_window",
          {31'd0, (lat >= TIMEOUT_CYC + 1 && lat <= TIMEOUT_CYC + 8)}, 1);
    check("timeout_err", {31'd0, err_seen}, 1);
    check("timeout_busy_held", {31'd0, busy_ok}, 1);
`else
    busy_ok = 1'b1;
    for (int c = 1; c <= TIMEOUT_CYC + 80; c++) begin
      #1;
      Req = 1'b0;
      if (!Busy || Done || Err) busy_ok = 1'b0;
      @(posedge Clk0);
    end
    check("no_timeout_busy_held", {31'd0, busy_ok}, 1);
    #1 Rst = 1'b0;
    @(negedge Clk0) Rst = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
